// File: rtl/ddr4_cmd_scheduler.sv
// rtl/ddr4_cmd_scheduler.sv - DDR4 single-request command sequencer with open-page row tracking.
// Optional refresh engine (PREA/REF on a TREFI interval) is enabled by DDR4_SCHED_REFRESH_EN.
module ddr4_cmd_scheduler #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int BL        = 8,
  parameter int TRCD      = 15,
  parameter int TCL       = 15,
  parameter int TRP       = 15,
  parameter int TREFI     = 6240,
  parameter int TRFC      = 260
) (
  input  logic                 ck_t,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [BGWIDTH-1:0]   req_bg,
  input  logic [BAWIDTH-1:0]   req_ba,
  input  logic [ADDRWIDTH-1:0] req_row,
  input  logic [COLWIDTH-1:0]  req_col,
  output logic                 cs_n,
  output logic                 act_n,
  output logic [BGWIDTH-1:0]   bg,
  output logic [BAWIDTH-1:0]   ba,
  output logic [ADDRWIDTH-1:0] A,
  output logic                 data_en,
  output logic                 data_wr,
  output logic                 busy
);

  localparam int BKW   = BGWIDTH + BAWIDTH;
  localparam int NBANK = 1 << BKW;
  localparam int M0    = (TRP > TRCD) ? TRP : TRCD;
  localparam int M1    = (M0 > TCL) ? M0 : TCL;
  localparam int M2    = (M1 > BL) ? M1 : BL;
  localparam int TMAX  = (M2 > TRFC) ? M2 : TRFC;
  localparam int TW    = $clog2(TMAX + 1);

  localparam logic [TW-1:0] RP_LOAD  = TW'((TRP  > 1) ? TRP  - 2 : 0);
  localparam logic [TW-1:0] RCD_LOAD = TW'((TRCD > 1) ? TRCD - 2 : 0);
  localparam logic [TW-1:0] CL_LOAD  = TW'((TCL  > 1) ? TCL  - 2 : 0);
  localparam logic [TW-1:0] BL_LOAD  = TW'(BL - 1);

  // A16/A15/A14 carry RAS_n/CAS_n/WE_n whenever act_n is high
  localparam logic [ADDRWIDTH-1:0] A_PRE = ADDRWIDTH'(17'h08000);
  localparam logic [ADDRWIDTH-1:0] A_WR  = ADDRWIDTH'(17'h10000);
  localparam logic [ADDRWIDTH-1:0] A_RD  = ADDRWIDTH'(17'h14000);

  if (BL < 1 || TRCD < 1 || TCL < 1 || TRP < 1 || TREFI < 1 || TRFC < 1 ||
      ADDRWIDTH < 17 || COLWIDTH > 10) begin : g_param_check
    $error("ddr4_cmd_scheduler: illegal timing or width parameter");
  end

`ifdef DDR4_SCHED_REFRESH_EN
  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_CAS, S_WAIT_CL, S_BURST,
    S_PREA, S_WAIT_RPA, S_REF, S_WAIT_RFC
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_CAS, S_WAIT_CL, S_BURST
  } state_t;
`endif

  state_t                 r_state, w_state_nxt;
  logic [TW-1:0]          r_timer, w_timer_nxt;

  logic                   r_req_write;
  logic [BGWIDTH-1:0]     r_req_bg;
  logic [BAWIDTH-1:0]     r_req_ba;
  logic [ADDRWIDTH-1:0]   r_req_row;
  logic [COLWIDTH-1:0]    r_req_col;

  logic [NBANK-1:0]       r_bank_valid;
  logic [ADDRWIDTH-1:0]   r_bank_row [NBANK];

  logic                   r_req_ready, r_cs_n, r_act_n, r_data_en, r_data_wr, r_busy;
  logic [BGWIDTH-1:0]     r_bg;
  logic [BAWIDTH-1:0]     r_ba;
  logic [ADDRWIDTH-1:0]   r_a;

  logic                   w_accept, w_bank_valid, w_row_match;
  logic [BKW-1:0]         w_req_idx, w_lat_idx;
  logic                   w_cur_write;
  logic [BGWIDTH-1:0]     w_cur_bg;
  logic [BAWIDTH-1:0]     w_cur_ba;
  logic [ADDRWIDTH-1:0]   w_cur_row;
  logic [COLWIDTH-1:0]    w_cur_col;
  logic                   w_cs_n, w_act_n, w_data_en, w_data_wr;
  logic [BGWIDTH-1:0]     w_bg;
  logic [BAWIDTH-1:0]     w_ba;
  logic [ADDRWIDTH-1:0]   w_a;

  assign w_accept     = r_req_ready & req_valid;
  assign w_req_idx    = {req_bg, req_ba};
  assign w_lat_idx    = {r_req_bg, r_req_ba};
  assign w_bank_valid = r_bank_valid[w_req_idx];
  assign w_row_match  = (r_bank_row[w_req_idx] == req_row);

  // Outputs are registered from the next state, so in IDLE the command fields come straight from the request
  assign w_cur_write = (r_state == S_IDLE) ? req_write : r_req_write;
  assign w_cur_bg    = (r_state == S_IDLE) ? req_bg    : r_req_bg;
  assign w_cur_ba    = (r_state == S_IDLE) ? req_ba    : r_req_ba;
  assign w_cur_row   = (r_state == S_IDLE) ? req_row   : r_req_row;
  assign w_cur_col   = (r_state == S_IDLE) ? req_col   : r_req_col;

`ifdef DDR4_SCHED_REFRESH_EN
  localparam int RW = $clog2(TREFI + 1);
  localparam logic [TW-1:0]        RFC_LOAD = TW'((TRFC > 1) ? TRFC - 2 : 0);
  localparam logic [ADDRWIDTH-1:0] A_PREA   = ADDRWIDTH'(17'h08400);
  localparam logic [ADDRWIDTH-1:0] A_REF    = ADDRWIDTH'(17'h04000);

  logic [RW-1:0] r_refi;
  logic          r_ref_pending, w_refi_expire, w_ref_done, w_pending_nxt, w_any_open;

  assign w_refi_expire = (r_refi == '0);
  assign w_pending_nxt = w_refi_expire | (r_ref_pending & ~w_ref_done);
  assign w_any_open    = |r_bank_valid;

  // Reload to TREFI-1 so expiries are exactly TREFI clocks apart
  always_ff @(posedge ck_t or negedge reset_n) begin
    if (!reset_n) begin
      r_refi        <= RW'(TREFI - 1);
      r_ref_pending <= 1'b0;
    end else begin
      r_refi        <= w_refi_expire ? RW'(TREFI - 1) : r_refi - RW'(1);
      r_ref_pending <= w_pending_nxt;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
`ifdef DDR4_SCHED_REFRESH_EN
    w_ref_done  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_bank_valid) w_state_nxt = w_row_match ? S_CAS : S_PRE;
          else              w_state_nxt = S_ACT;
        end
`ifdef DDR4_SCHED_REFRESH_EN
        else if (r_ref_pending) begin
          w_state_nxt = w_any_open ? S_PREA : S_REF;
        end
`endif
      end
      S_PRE: begin
        w_state_nxt = (TRP == 1) ? S_ACT : S_WAIT_RP;
        w_timer_nxt = RP_LOAD;
      end
      S_WAIT_RP: begin
        if (r_timer == '0) w_state_nxt = S_ACT;
        else               w_timer_nxt = r_timer - TW'(1);
      end
      S_ACT: begin
        w_state_nxt = (TRCD == 1) ? S_CAS : S_WAIT_RCD;
        w_timer_nxt = RCD_LOAD;
      end
      S_WAIT_RCD: begin
        if (r_timer == '0) w_state_nxt = S_CAS;
        else               w_timer_nxt = r_timer - TW'(1);
      end
      S_CAS: begin
        w_state_nxt = (TCL == 1) ? S_BURST : S_WAIT_CL;
        w_timer_nxt = (TCL == 1) ? BL_LOAD : CL_LOAD;
      end
      S_WAIT_CL: begin
        if (r_timer == '0) begin
          w_state_nxt = S_BURST;
          w_timer_nxt = BL_LOAD;
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end
      S_BURST: begin
        if (r_timer == '0) w_state_nxt = S_IDLE;
        else               w_timer_nxt = r_timer - TW'(1);
      end
`ifdef DDR4_SCHED_REFRESH_EN
      S_PREA: begin
        w_state_nxt = (TRP == 1) ? S_REF : S_WAIT_RPA;
        w_timer_nxt = RP_LOAD;
      end
      S_WAIT_RPA: begin
        if (r_timer == '0) w_state_nxt = S_REF;
        else               w_timer_nxt = r_timer - TW'(1);
      end
      S_REF: begin
        w_state_nxt = (TRFC == 1) ? S_IDLE : S_WAIT_RFC;
        w_timer_nxt = RFC_LOAD;
        w_ref_done  = (TRFC == 1);
      end
      S_WAIT_RFC: begin
        if (r_timer == '0) begin
          w_state_nxt = S_IDLE;
          w_ref_done  = 1'b1;
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cs_n    = 1'b1;
    w_act_n   = 1'b1;
    w_bg      = '0;
    w_ba      = '0;
    w_a       = '0;
    w_data_en = 1'b0;
    w_data_wr = 1'b0;
    case (w_state_nxt)
      S_PRE: begin
        w_cs_n = 1'b0;
        w_bg   = w_cur_bg;
        w_ba   = w_cur_ba;
        w_a    = A_PRE;
      end
      S_ACT: begin
        w_cs_n  = 1'b0;
        w_act_n = 1'b0;
        w_bg    = w_cur_bg;
        w_ba    = w_cur_ba;
        w_a     = w_cur_row;
      end
      S_CAS: begin
        w_cs_n = 1'b0;
        w_bg   = w_cur_bg;
        w_ba   = w_cur_ba;
        w_a    = (w_cur_write ? A_WR : A_RD) | {{(ADDRWIDTH-COLWIDTH){1'b0}}, w_cur_col};
      end
      S_BURST: begin
        w_data_en = 1'b1;
        w_data_wr = w_cur_write;
      end
`ifdef DDR4_SCHED_REFRESH_EN
      S_PREA: begin
        w_cs_n = 1'b0;
        w_a    = A_PREA;
      end
      S_REF: begin
        w_cs_n = 1'b0;
        w_a    = A_REF;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge ck_t or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_req_write  <= 1'b0;
      r_req_bg     <= '0;
      r_req_ba     <= '0;
      r_req_row    <= '0;
      r_req_col    <= '0;
      r_bank_valid <= '0;
      r_req_ready  <= 1'b0;
      r_cs_n       <= 1'b1;
      r_act_n      <= 1'b1;
      r_bg         <= '0;
      r_ba         <= '0;
      r_a          <= '0;
      r_data_en    <= 1'b0;
      r_data_wr    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_cs_n    <= w_cs_n;
      r_act_n   <= w_act_n;
      r_bg      <= w_bg;
      r_ba      <= w_ba;
      r_a       <= w_a;
      r_data_en <= w_data_en;
      r_data_wr <= w_data_wr;
      r_busy    <= (w_state_nxt != S_IDLE);
`ifdef DDR4_SCHED_REFRESH_EN
      r_req_ready <= (w_state_nxt == S_IDLE) & ~w_pending_nxt;
`else
      r_req_ready <= (w_state_nxt == S_IDLE);
`endif
      if (w_accept) begin
        r_req_write <= req_write;
        r_req_bg    <= req_bg;
        r_req_ba    <= req_ba;
        r_req_row   <= req_row;
        r_req_col   <= req_col;
      end
      if (r_state == S_PRE) r_bank_valid[w_lat_idx] <= 1'b0;
      if (r_state == S_ACT) r_bank_valid[w_lat_idx] <= 1'b1;
`ifdef DDR4_SCHED_REFRESH_EN
      if (r_state == S_PREA) r_bank_valid <= '0;
`endif
    end
  end

  // Row contents only matter while the matching valid bit is set
  always_ff @(posedge ck_t) begin
    if (r_state == S_ACT) r_bank_row[w_lat_idx] <= r_req_row;
  end

  assign req_ready = r_req_ready;
  assign cs_n      = r_cs_n;
  assign act_n     = r_act_n;
  assign bg        = r_bg;
  assign ba        = r_ba;
  assign A         = r_a;
  assign data_en   = r_data_en;
  assign data_wr   = r_data_wr;
  assign busy      = r_busy;

endmodule
